// File: rtl/id_pkg.sv
// Shared constants for the decode stage: opcodes, funct fields, operation codes
// and the width of the decoded bundle carried through the output queue.
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int OH_LUI   = 1;
    localparam int OH_JAL   = 3;
    localparam int OH_BEQ   = 5;
    localparam int OH_BNE   = 6;
    localparam int OH_BLT   = 7;
    localparam int OH_BGE   = 8;
    localparam int OH_BLTU  = 9;
    localparam int OH_BGEU  = 10;
    localparam int OH_ADDI  = 19;
    localparam int OH_SLTI  = 20;
    localparam int OH_SLTIU = 21;
    localparam int OH_SLLI  = 25;
    localparam int OH_SRLI  = 26;
    localparam int OH_SRAI  = 27;
    localparam int OH_ADD   = 28;
    localparam int OH_SUB   = 29;

    // Where op1/op2 come from for the decoded instruction.
    typedef enum logic [1:0] {
        OPS_ZERO   = 2'd0,
        OPS_RS_IMM = 2'd1,
        OPS_RS_RS  = 2'd2,
        OPS_RS_SH  = 2'd3
    } op_sel_e;

    // {illegal, oh, rd_wen, rd_addr, ins, ins_addr, imm, op2, op1}
    function automatic int id_bundle_w(input int xlen, input int oh_w);
        return 4 * xlen + 32 + 5 + 1 + oh_w + 1;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Parametrised DEPTH-entry queue holding decoded bundles; flush empties it at
// the next edge and takes priority over push and pop.
module id_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    assign o_dout  = r_mem[r_rptr];

    // Payload storage carries no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/id_stage_q.sv
// Decode stage: combinational decode + regfile read in front of an id_fifo queue.
// Build option ID_FWD_EN enables same-cycle EX->ID operand forwarding.
module id_stage_q
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int OH_W  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] ins_addr2id,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            fwd_wen,
    input  logic [4:0]      fwd_addr,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] imm,
    output logic [31:0]     ins2ex,
    output logic [XLEN-1:0] ins_addr,
    output logic [4:0]      rd_addr,
    output logic            rd_wen,
    output logic [OH_W-1:0] oh,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int BW  = id_bundle_w(XLEN, OH_W);
    localparam int HIW = 12 - SHW;
    // Upper immediate bits that distinguish SRAI from SRLI (ins[30] set).
    localparam logic [HIW-1:0] SRAI_HI = HIW'(1 << (10 - SHW));

    logic [6:0]     w_opc;
    logic [2:0]     w_f3;
    logic [6:0]     w_f7;
    logic [HIW-1:0] w_shf_hi;

    assign w_opc    = ins[6:0];
    assign w_f3     = ins[14:12];
    assign w_f7     = ins[31:25];
    assign w_shf_hi = ins[31:20+SHW];

    logic [31:0]     w_imm_i32, w_imm_b32, w_imm_u32, w_imm_j32;
    logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j, w_shamt;

    assign w_imm_i32 = {{20{ins[31]}}, ins[31:20]};
    assign w_imm_b32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign w_imm_u32 = {ins[31:12], 12'b0};
    assign w_imm_j32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign w_imm_i   = XLEN'($signed(w_imm_i32));
    assign w_imm_b   = XLEN'($signed(w_imm_b32));
    assign w_imm_u   = XLEN'($signed(w_imm_u32));
    assign w_imm_j   = XLEN'($signed(w_imm_j32));
    assign w_shamt   = XLEN'(ins[20+:SHW]);

    logic [OH_W-1:0] w_oh;
    logic            w_illegal;
    logic            w_rd_wen;
    logic            w_use_rs1;
    logic            w_use_rs2;
    op_sel_e         w_sel;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_oh      = '0;
        w_illegal = 1'b1;
        w_rd_wen  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_sel     = OPS_ZERO;
        w_imm     = '0;
        case (w_opc)
            OPC_LUI: begin
                w_oh      = OH_W'(OH_LUI);
                w_illegal = 1'b0;
                w_rd_wen  = 1'b1;
                w_imm     = w_imm_u;
            end
            OPC_JAL: begin
                w_oh      = OH_W'(OH_JAL);
                w_illegal = 1'b0;
                w_rd_wen  = 1'b1;
                w_imm     = w_imm_j;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    F3_BEQ:  begin w_oh = OH_W'(OH_BEQ);  w_illegal = 1'b0; end
                    F3_BNE:  begin w_oh = OH_W'(OH_BNE);  w_illegal = 1'b0; end
                    F3_BLT:  begin w_oh = OH_W'(OH_BLT);  w_illegal = 1'b0; end
                    F3_BGE:  begin w_oh = OH_W'(OH_BGE);  w_illegal = 1'b0; end
                    F3_BLTU: begin w_oh = OH_W'(OH_BLTU); w_illegal = 1'b0; end
                    F3_BGEU: begin w_oh = OH_W'(OH_BGEU); w_illegal = 1'b0; end
                    default: ;
                endcase
                if (!w_illegal) begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_sel     = OPS_RS_RS;
                    w_imm     = w_imm_b;
                end
            end
            OPC_OPIMM: begin
                case (w_f3)
                    F3_ADD:  begin w_oh = OH_W'(OH_ADDI);  w_illegal = 1'b0; w_sel = OPS_RS_IMM; end
                    F3_SLT:  begin w_oh = OH_W'(OH_SLTI);  w_illegal = 1'b0; w_sel = OPS_RS_IMM; end
                    F3_SLTU: begin w_oh = OH_W'(OH_SLTIU); w_illegal = 1'b0; w_sel = OPS_RS_IMM; end
                    F3_SLL: begin
                        if (w_shf_hi == '0) begin
                            w_oh = OH_W'(OH_SLLI); w_illegal = 1'b0; w_sel = OPS_RS_SH;
                        end
                    end
                    F3_SR: begin
                        if (w_shf_hi == '0) begin
                            w_oh = OH_W'(OH_SRLI); w_illegal = 1'b0; w_sel = OPS_RS_SH;
                        end else if (w_shf_hi == SRAI_HI) begin
                            w_oh = OH_W'(OH_SRAI); w_illegal = 1'b0; w_sel = OPS_RS_SH;
                        end
                    end
                    default: ;
                endcase
                if (!w_illegal) begin
                    w_use_rs1 = 1'b1;
                    w_rd_wen  = 1'b1;
                    w_imm     = w_imm_i;
                end
            end
            OPC_OP: begin
                if (w_f3 == F3_ADD && w_f7 == F7_BASE) begin
                    w_oh = OH_W'(OH_ADD); w_illegal = 1'b0;
                end else if (w_f3 == F3_ADD && w_f7 == F7_ALT) begin
                    w_oh = OH_W'(OH_SUB); w_illegal = 1'b0;
                end
                if (!w_illegal) begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_rd_wen  = 1'b1;
                    w_sel     = OPS_RS_RS;
                end
            end
            default: ;
        endcase
    end

    assign rs1_addr = w_use_rs1 ? ins[19:15] : 5'd0;
    assign rs2_addr = w_use_rs2 ? ins[24:20] : 5'd0;

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

`ifdef ID_FWD_EN
    assign w_rs1_val = (rs1_addr == 5'd0) ? '0 :
                       (fwd_wen && fwd_addr == rs1_addr) ? fwd_data : rs1_data;
    assign w_rs2_val = (rs2_addr == 5'd0) ? '0 :
                       (fwd_wen && fwd_addr == rs2_addr) ? fwd_data : rs2_data;
`else
    // Forwarding ports exist in this build only for interface compatibility.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_wen, fwd_addr, fwd_data};
    assign w_rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign w_rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;
`endif

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (w_sel)
            OPS_RS_IMM: begin w_op1 = w_rs1_val; w_op2 = w_imm_i;   end
            OPS_RS_RS:  begin w_op1 = w_rs1_val; w_op2 = w_rs2_val; end
            OPS_RS_SH:  begin w_op1 = w_rs1_val; w_op2 = w_shamt;   end
            default: ;
        endcase
    end

    logic [BW-1:0] w_din;
    logic [BW-1:0] w_dout;
    logic [BW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_din = {w_illegal, w_oh, w_rd_wen, (w_rd_wen ? ins[11:7] : 5'd0),
                    ins, ins_addr2id, w_imm, w_op2, w_op1};

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    id_fifo #(
        .W     (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Payload is forced to zero whenever the head is not valid.
    assign w_head   = out_valid ? w_dout : '0;
    assign op1      = w_head[XLEN-1:0];
    assign op2      = w_head[2*XLEN-1:XLEN];
    assign imm      = w_head[3*XLEN-1:2*XLEN];
    assign ins_addr = w_head[4*XLEN-1:3*XLEN];
    assign ins2ex   = w_head[4*XLEN+31:4*XLEN];
    assign rd_addr  = w_head[4*XLEN+36:4*XLEN+32];
    assign rd_wen   = w_head[4*XLEN+37];
    assign oh       = w_head[4*XLEN+38+:OH_W];
    assign illegal  = w_head[4*XLEN+38+OH_W];

endmodule

// File: tb/tb_id_stage_q.sv
// Directed bench for id_stage_q: a 32-bit instance for the main scenarios and a
// 64-bit instance for wide shift-amount decode.
module tb_id_stage_q;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid, in_ready, flush, fwd_wen, out_valid, out_ready;
    logic [31:0] ins, ins_addr2id, rs1_data, rs2_data, fwd_data;
    logic [4:0]  rs1_addr, rs2_addr, fwd_addr, rd_addr;
    logic [31:0] op1, op2, imm, ins2ex, ins_addr;
    logic        rd_wen, illegal;
    logic [6:0]  oh;

    id_stage_q #(.XLEN(32), .DEPTH(2), .OH_W(7)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .ins_addr2id(ins_addr2id), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_wen(fwd_wen), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .imm(imm),
        .ins2ex(ins2ex), .ins_addr(ins_addr), .rd_addr(rd_addr), .rd_wen(rd_wen),
        .oh(oh), .illegal(illegal)
    );

    // 64-bit instance
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [31:0] ins_b, ins2ex_b;
    logic [63:0] ins_addr2id_b, rs1_data_b, rs2_data_b, fwd_data_b;
    logic [4:0]  rs1_addr_b, rs2_addr_b, rd_addr_b;
    logic [63:0] op1_b, op2_b, imm_b, ins_addr_b;
    logic        rd_wen_b, illegal_b;
    logic [6:0]  oh_b;

    id_stage_q #(.XLEN(64), .DEPTH(2), .OH_W(7)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .ins(ins_b), .ins_addr2id(ins_addr2id_b), .flush(1'b0),
        .rs1_addr(rs1_addr_b), .rs2_addr(rs2_addr_b), .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .fwd_wen(1'b0), .fwd_addr(5'd0), .fwd_data(fwd_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .op1(op1_b), .op2(op2_b), .imm(imm_b),
        .ins2ex(ins2ex_b), .ins_addr(ins_addr_b), .rd_addr(rd_addr_b), .rd_wen(rd_wen_b),
        .oh(oh_b), .illegal(illegal_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI = 32'hFFF10093; // addi x1,x2,-1
    localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADD0 = 32'h002001B3; // add  x3,x0,x2
    localparam logic [31:0] I_SUB  = 32'h40628233; // sub  x4,x5,x6
    localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5,0x12345
    localparam logic [31:0] I_BNE  = 32'h00209463; // bne  x1,x2,+8
    localparam logic [31:0] I_SRAI = 32'h42845393; // srai x7,x8,40 (RV64)

    logic [31:0] exp_fwd;

    initial begin
`ifdef ID_FWD_EN
        exp_fwd = 32'h10;
`else
        exp_fwd = 32'h99;
`endif
        rst = 1'b1;
        in_valid = 0; flush = 0; fwd_wen = 0; out_ready = 0;
        ins = 0; ins_addr2id = 0; rs1_data = 0; rs2_data = 0; fwd_addr = 0; fwd_data = 0;
        in_valid_b = 0; out_ready_b = 0; ins_b = 0; ins_addr2id_b = 0;
        rs1_data_b = 0; rs2_data_b = 0; fwd_data_b = 0;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_op1", 64'(op1), 64'd0);
        check("rst_oh", 64'(oh), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ADDI x1,x2,-1
        ins = I_ADDI; ins_addr2id = 32'h100; rs1_data = 32'd5; in_valid = 1;
        #1;
        check("addi_rs1_addr", 64'(rs1_addr), 64'd2);
        check("addi_rs2_addr", 64'(rs2_addr), 64'd0);
        tick();
        in_valid = 0;
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_oh", 64'(oh), 64'd19);
        check("addi_op1", 64'(op1), 64'd5);
        check("addi_op2", 64'(op2), 64'hFFFFFFFF);
        check("addi_imm", 64'(imm), 64'hFFFFFFFF);
        check("addi_rd", 64'(rd_addr), 64'd1);
        check("addi_wen", 64'(rd_wen), 64'd1);
        check("addi_ins_addr", 64'(ins_addr), 64'h100);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("pop_empty_valid", 64'(out_valid), 64'd0);
        check("pop_empty_op1", 64'(op1), 64'd0);

        // Fill a DEPTH=2 queue, hold a third, then drain
        rs1_data = 32'h11; rs2_data = 32'h22;
        ins = I_ADD; in_valid = 1; tick();
        ins = I_SUB; tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        ins = I_LUI; tick();
        check("held_in_ready", 64'(in_ready), 64'd0);
        check("held_head_oh", 64'(oh), 64'd28);
        check("held_head_rd", 64'(rd_addr), 64'd3);
        out_ready = 1;
        tick();
        check("drain1_oh", 64'(oh), 64'd29);
        check("drain1_rd", 64'(rd_addr), 64'd4);
        check("drain1_op2", 64'(op2), 64'h22);
        check("drain1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        check("drain2_oh", 64'(oh), 64'd1);
        check("drain2_imm", 64'(imm), 64'h12345000);
        check("drain2_op1", 64'(op1), 64'd0);
        check("drain2_rd", 64'(rd_addr), 64'd5);
        tick();
        check("drain3_valid", 64'(out_valid), 64'd0);
        out_ready = 0;

        // Flush with two queued plus an incoming instruction
        ins = I_ADDI; in_valid = 1; tick();
        ins = I_ADD; tick();
        ins = I_SUB; flush = 1; tick();
        flush = 0; in_valid = 0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("flush_stays_empty", 64'(out_valid), 64'd0);
        ins = I_LUI; in_valid = 1; tick();
        in_valid = 0;
        check("post_flush_oh", 64'(oh), 64'd1);
        out_ready = 1; tick(); out_ready = 0;
        check("post_flush_empty", 64'(out_valid), 64'd0);

        // Forwarding and x0
        ins = I_ADD; rs1_data = 32'h99; rs2_data = 32'h7;
        fwd_wen = 1; fwd_addr = 5'd1; fwd_data = 32'h10; in_valid = 1;
        tick();
        check("fwd_op1", 64'(op1), 64'(exp_fwd));
        check("fwd_op2", 64'(op2), 64'h7);
        out_ready = 1; fwd_addr = 5'd0;
        tick();
        check("nofwd_op1", 64'(op1), 64'h99);
        ins = I_ADD0;
        tick();
        in_valid = 0; fwd_wen = 0;
        check("x0_op1", 64'(op1), 64'd0);
        check("x0_op2", 64'(op2), 64'h7);
        tick();
        out_ready = 0;

        // Branch and illegal encodings
        ins = I_BNE; rs1_data = 32'hA; rs2_data = 32'hB; in_valid = 1;
        tick();
        check("bne_oh", 64'(oh), 64'd6);
        check("bne_wen", 64'(rd_wen), 64'd0);
        check("bne_imm", 64'(imm), 64'd8);
        check("bne_ops", {op1, op2}, {32'hA, 32'hB});
        out_ready = 1;
        ins = 32'hFFFFFFFF;
        #1;
        check("ill_rs1_addr", 64'(rs1_addr), 64'd0);
        tick();
        in_valid = 0;
        check("ill_valid", 64'(out_valid), 64'd1);
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_oh", 64'(oh), 64'd0);
        check("ill_wen", 64'(rd_wen), 64'd0);
        check("ill_ins2ex", 64'(ins2ex), 64'hFFFFFFFF);
        tick();
        out_ready = 0;

        // RV64 SRAI with a 6-bit shift amount
        ins_b = I_SRAI; rs1_data_b = 64'h8000_0000_0000_0000; in_valid_b = 1;
        tick();
        in_valid_b = 0;
        check("srai64_valid", 64'(out_valid_b), 64'd1);
        check("srai64_oh", 64'(oh_b), 64'd27);
        check("srai64_op2", op2_b, 64'd40);
        check("srai64_op1", op1_b, 64'h8000_0000_0000_0000);
        check("srai64_rd", 64'(rd_addr_b), 64'd7);
        check("srai64_illegal", 64'(illegal_b), 64'd0);

        // Reset mid-stream
        ins = I_ADDI; in_valid = 1; tick();
        in_valid = 0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_valid64", 64'(out_valid_b), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
